// File: rtl/matmul_operand_loader.sv
// Operand loader for the 2x2 matrix multiplier: packs a framed element stream
// into A/B operands, launches the multiplier and supervises completion.
//
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   in_data/in_valid/in_last/in_ready
//                   element stream handshake (8 elements per frame)
//   A, B            packed operands {x00, x01, x10, x11}, MSB first
//   start           one-cycle launch pulse, A/B valid in that cycle
//   done            multiplier completion, level or pulse
//   busy            operation in flight (LAUNCH or WAIT)
//   err_frame       sticky framing error
//   err_timeout     sticky done-watchdog error
//   err_clr         clears both sticky errors
module matmul_operand_loader #(
  parameter int ELEM_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [4*ELEM_W-1:0] A,
  output logic [4*ELEM_W-1:0] B,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err_frame,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [TW-1:0]     timer;
  logic [ELEM_W-1:0] shadow [8];

  logic hs;
  logic last_slot;
  logic wdog_hit;

  assign hs        = in_valid & in_ready;
  assign last_slot = (idx == 3'd7);
  assign wdog_hit  = WDOG_EN && (timer == TLAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      idx         <= 3'd0;
      timer       <= '0;
      A           <= '0;
      B           <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      // Clear first so that an error raised in the same cycle overrides it.
      if (err_clr) begin
        err_frame   <= 1'b0;
        err_timeout <= 1'b0;
      end

      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (hs) begin
            shadow[idx] <= in_data;
            if (in_last != last_slot) begin
              // Early or missing in_last: drop the frame.
              err_frame <= 1'b1;
              idx       <= 3'd0;
            end else if (last_slot) begin
              // Final element bypasses its shadow slot.
              A        <= {shadow[0], shadow[1],
                           shadow[2], shadow[3]};
              B        <= {shadow[4], shadow[5],
                           shadow[6], in_data};
              start    <= 1'b1;
              busy     <= 1'b1;
              in_ready <= 1'b0;
              idx      <= 3'd0;
              state    <= LAUNCH;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        LAUNCH: begin
          // done is deliberately not looked at here.
          start <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (done) begin
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= LOAD;
          end else if (wdog_hit) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
            state       <= LOAD;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          start    <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          idx      <= 3'd0;
          state    <= LOAD;
        end
      endcase
    end
  end

endmodule
